exe_result_buffer: RTL
======================

// Module: exe_result_buffer
// PURPOSE
//  Downstream stage of exe_unit_w15: captures each {o_status, o_result} pair the
//  execution unit produces and queues it in a DEPTH-entry FIFO. Entries drain to
//  the consumer over a valid/ready handshake. Overflow is reported, never silent.
// PARAMETERS
//  ARG_BITS  4  width of result word; must equal exe_unit_w15 ARG_BITS
//  DEPTH     4  FIFO entries; power of two, >= 2
// PORTS
//  i_clk     in   1             clock, all state updates on rising edge
//  i_rst     in   1             asynchronous reset, active-high
//  i_wvalid  in   1             producer strobe: i_result/i_status valid this cycle
//  i_result  in   ARG_BITS      result word from execution unit
//  i_status  in   4             status flags from execution unit
//  o_rvalid  out  1             head entry available
//  i_rready  in   1             consumer accepts head entry
//  o_result  out  ARG_BITS      head entry result
//  o_status  out  4             head entry status
//  o_level   out  clog2(DEPTH+1) occupied entries
//  o_full    out  1             level == DEPTH
//  o_drop    out  1             one-cycle pulse: write rejected this cycle
//  o_ovf     out  1             sticky overflow flag
//  i_clr     in   1             synchronous clear of o_ovf (and drop counter)
// BEHAVIOUR
//  - Reset (async, any time incl. mid-transfer): wr/rd pointers 0, level 0,
//    o_rvalid 0, o_full 0, o_drop 0, o_ovf 0; stored entries discarded.
//  - Push = i_wvalid & (!o_full | pop). Pop = o_rvalid & i_rready.
//  - Latency: push in cycle N -> o_rvalid high in N+1 (no fall-through bypass).
//  - o_result/o_status = mem[rd_ptr], combinational from registered storage;
//    stable while o_rvalid & !i_rready. Don't-care (not X-checked) when empty.
//  - Pointers log2(DEPTH) bits, wrap naturally DEPTH-1 -> 0.
//  - Level: +1 push only, -1 pop only, unchanged on both or neither.
//  - Full & pop & i_wvalid same cycle: both accepted, level stays DEPTH, no drop.
//  - Empty & i_rready: no pop, level stays 0, no underflow.
//  - Full & !pop & i_wvalid: entry dropped, o_drop=1 next cycle for one cycle,
//    o_ovf set; FIFO contents unchanged.
//  - i_clr & new drop same cycle: set wins, o_ovf stays 1.
//  - No state machine beyond pointers/level; o_full, o_rvalid derived from level.
// CONFIGURATION
//  RESBUF_DROP_CNT_EN defined: adds port o_drop_cnt out 8, counts dropped
//   writes, saturates at 255, reset 0, zeroed by i_clr (drop same cycle -> 1).
//  Undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  exe_pkg: STATUS_W=4 constant, status bit indices (ST_ZERO=0, ST_CARRY=1,
//   ST_OVF=2, ST_ERR=3), typedef exe_entry_t {status, result} parameterised
//   by ARG_BITS via localparam in user.
//  One sub-module: exe_fifo_mem (DEPTH x entry register array, write port,
//   async read port). Control (pointers, level, flags) stays in top.
// TESTING  (ARG_BITS=4, DEPTH=4, compare against behavioural queue model)
//  1 Reset: assert i_rst mid-cycle -> all outputs 0 immediately, level 0.
//  2 Push 3,7,9 with i_rready=0 -> level 3; then i_rready=1 -> pops 3,7,9 in
//    order, o_rvalid drops after third pop.
//  3 Fill 4 entries, push 5 with i_rready=0 -> o_drop one-cycle pulse, o_ovf=1,
//    level 4, head unchanged; i_clr -> o_ovf=0.
//  4 Full, i_wvalid=1 & i_rready=1 with value 12 -> no drop, level 4, 12 read
//    out after 4 pops.
//  5 Empty, i_rready=1 for 5 cycles -> o_rvalid=0, level 0; push 6 -> o_rvalid
//    exactly one cycle later.
//  6 RESBUF_DROP_CNT_EN: 300 drops while full -> o_drop_cnt=255; i_clr -> 0.

Source files
------------

// File: rtl/exe_pkg.sv
// Shared definitions for the execution-unit result path: status layout and
// helpers used by the result buffer and its storage.
package exe_pkg;

   localparam int STATUS_W   = 4;
   localparam int ST_ZERO    = 0;
   localparam int ST_CARRY   = 1;
   localparam int ST_OVF     = 2;
   localparam int ST_ERR     = 3;
   localparam int DROP_CNT_W = 8;

   // Saturating increment for the dropped-write counter.
   function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
      return (v == {DROP_CNT_W{1'b1}}) ? v : v + DROP_CNT_W'(1);
   endfunction

endpackage

// File: rtl/exe_fifo_mem.sv
// DEPTH x WIDTH register array with one synchronous write port and one
// asynchronous read port; holds the result-buffer entries.
module exe_fifo_mem #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [PTR_W-1:0] waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [PTR_W-1:0] raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // No reset: contents are only observed through the level-qualified head.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/exe_result_buffer.sv
// Result FIFO behind the execution unit with valid/ready drain and overflow
// reporting. Define RESBUF_DROP_CNT_EN to add the saturating o_drop_cnt port.
module exe_result_buffer
   import exe_pkg::*;
#(
   parameter int ARG_BITS = 4,
   parameter int DEPTH    = 4
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_wvalid,
   input  logic [ARG_BITS-1:0]        i_result,
   input  logic [STATUS_W-1:0]        i_status,
   output logic                       o_rvalid,
   input  logic                       i_rready,
   output logic [ARG_BITS-1:0]        o_result,
   output logic [STATUS_W-1:0]        o_status,
   output logic [$clog2(DEPTH+1)-1:0] o_level,
   output logic                       o_full,
   output logic                       o_drop,
   output logic                       o_ovf,
   input  logic                       i_clr
`ifdef RESBUF_DROP_CNT_EN
   ,
   output logic [DROP_CNT_W-1:0]      o_drop_cnt
`endif
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int LVL_W   = $clog2(DEPTH+1);
   localparam int ENTRY_W = STATUS_W + ARG_BITS;

   typedef struct packed {
      logic [STATUS_W-1:0] status;
      logic [ARG_BITS-1:0] result;
   } exe_entry_t;

   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [LVL_W-1:0] level_reg;
   logic             drop_reg;
   logic             ovf_reg;
   logic             push;
   logic             pop;
   logic             drop_now;
   exe_entry_t       wr_entry;
   exe_entry_t       rd_entry;

   assign o_rvalid = (level_reg != '0);
   assign o_full   = (level_reg == LVL_W'(DEPTH));
   assign o_level  = level_reg;
   assign o_drop   = drop_reg;
   assign o_ovf    = ovf_reg;

   // A full FIFO still accepts a write when the head leaves in the same cycle.
   assign pop      = o_rvalid & i_rready;
   assign push     = i_wvalid & (~o_full | pop);
   assign drop_now = i_wvalid & ~push;

   assign wr_entry = '{status: i_status, result: i_result};
   assign o_result = rd_entry.result;
   assign o_status = rd_entry.status;

   exe_fifo_mem #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W),
      .PTR_W (PTR_W)
   ) u_mem (
      .clk   (i_clk),
      .we    (push),
      .waddr (wr_ptr_reg),
      .wdata (wr_entry),
      .raddr (rd_ptr_reg),
      .rdata (rd_entry)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
         drop_reg   <= 1'b0;
         ovf_reg    <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   level_reg <= level_reg + LVL_W'(1);
            2'b01:   level_reg <= level_reg - LVL_W'(1);
            default: level_reg <= level_reg;
         endcase
         drop_reg <= drop_now;
         // A fresh drop beats a clear in the same cycle.
         if (drop_now) begin
            ovf_reg <= 1'b1;
         end else if (i_clr) begin
            ovf_reg <= 1'b0;
         end
      end
   end

`ifdef RESBUF_DROP_CNT_EN
   logic [DROP_CNT_W-1:0] drop_cnt_reg;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         drop_cnt_reg <= '0;
      end else if (i_clr) begin
         drop_cnt_reg <= drop_now ? DROP_CNT_W'(1) : '0;
      end else if (drop_now) begin
         drop_cnt_reg <= sat_inc(drop_cnt_reg);
      end
   end

   assign o_drop_cnt = drop_cnt_reg;
`endif

endmodule
